// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : param_sync_fifo
//  Description : Parametrised single-clock FIFO with valid/ready handshakes
//                on both sides. It has a registered first-word output, a
//                fill-level count, and registered almost-full/almost-empty
//                flags.
//                Defining PARAM_SYNC_FIFO_ERR_EN adds two sticky flags:
//                overflow_err and underflow_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_sync_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       almost_empty
`ifdef PARAM_SYNC_FIFO_ERR_EN
    ,
    output logic                       overflow_err,
    output logic                       underflow_err
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_CNT   = c_CNT_W'(AF_LEVEL);
    localparam logic [c_CNT_W-1:0] c_AE_CNT   = c_CNT_W'(AE_LEVEL);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_almost_full;
    logic               r_almost_empty;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_fire;
    logic               w_rd_fire;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;

    // Status comes only from the registered count, so handshakes never see a
    // combinational path from the inputs.
    assign w_full       = (r_count == c_FULL_CNT);
    assign w_empty      = (r_count == '0);
    assign w_wr_fire    = in_valid  & ~w_full;
    assign w_rd_fire    = out_ready & ~w_empty;
    assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;

    assign in_ready     = ~w_full;
    assign out_valid    = ~w_empty;
    assign out_data     = r_out_data;
    assign count        = r_count;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;

    // Next fill level: +1 on write only, -1 on read only, else unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_fire, w_rd_fire})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers, count and the threshold flags, all computed from the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_count        <= w_count_nxt;
            r_almost_full  <= (w_count_nxt >= c_AF_CNT);
            r_almost_empty <= (w_count_nxt <= c_AE_CNT);
        end
    end

    // First-word register. It reloads on a read, taking the next entry or,
    // when the last entry leaves, the word written in the same cycle. It
    // also loads when a word is written into an empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
        end else if (w_rd_fire) begin
            if (r_count == c_CNT_ONE) begin
                if (w_wr_fire) begin
                    r_out_data <= in_data;
                end
            end else begin
                r_out_data <= r_mem[w_rd_ptr_nxt];
            end
        end else if (w_wr_fire && w_empty) begin
            r_out_data <= in_data;
        end
    end

`ifdef PARAM_SYNC_FIFO_ERR_EN
    logic r_overflow_err;
    logic r_underflow_err;

    assign overflow_err  = r_overflow_err;
    assign underflow_err = r_underflow_err;

    // Sticky flags for requests that the handshake refused; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            if (in_valid && w_full) begin
                r_overflow_err <= 1'b1;
            end
            if (out_ready && w_empty) begin
                r_underflow_err <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_sync_fifo
//  Description : Self-checking bench for param_sync_fifo. A queue model is
//                checked every cycle and is backed by literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_sync_fifo;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int AE_LEVEL = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        count;
    logic              almost_full;
    logic              almost_empty;
`ifdef PARAM_SYNC_FIFO_ERR_EN
    logic              overflow_err;
    logic              underflow_err;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: a plain queue plus two sticky bits.
    logic [DATA_W-1:0] q[$];
    bit  m_ovf = 1'b0;
    bit  m_unf = 1'b0;
    int  m_sz;

    param_sync_fifo #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
`ifdef PARAM_SYNC_FIFO_ERR_EN
        .overflow_err (overflow_err),
        .underflow_err(underflow_err),
`endif
        .almost_full (almost_full),
        .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Update the model from the handshake rules at each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_sz = q.size();
            if (in_valid && m_sz == DEPTH) m_ovf = 1'b1;
            if (out_ready && m_sz == 0)    m_unf = 1'b1;
            if (out_ready && m_sz > 0)     void'(q.pop_front());
            if (in_valid && m_sz < DEPTH)  q.push_back(in_data);
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("m_almost_full", 32'(almost_full), 32'(q.size() >= AF_LEVEL));
            chk("m_almost_empty", 32'(almost_empty), 32'(q.size() <= AE_LEVEL));
            if (q.size() > 0) chk("m_out_data", 32'(out_data), 32'(q[0]));
`ifdef PARAM_SYNC_FIFO_ERR_EN
            chk("m_overflow_err", 32'(overflow_err), 32'(m_ovf));
            chk("m_underflow_err", 32'(underflow_err), 32'(m_unf));
`endif
        end
    end

    // Drive one cycle of inputs at the falling edge, then settle just after the rising edge.
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pw;
        int pr;
        // Reset and idle.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_almost_full", 32'(almost_full), 32'd0);

        // Fill with 0x01..0x10, no reads.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, DATA_W'(i), 1'b0);
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_almost_full", 32'(almost_full), (i >= 12) ? 32'd1 : 32'd0);
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 8'h11, 1'b0);
        chk("full_17th_ignored", 32'(count), 32'd16);

        // Drain in order.
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("drain_data", 32'(out_data), 32'(i));
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);

        // Hold at 8 entries with simultaneous traffic; the pointers wrap.
        for (int i = 0; i < 8; i++) step(1'b1, DATA_W'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, DATA_W'(8'h40 + i), 1'b1);
            chk("steady_count", 32'(count), 32'd8);
        end
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        chk("steady_drained", 32'(count), 32'd0);

        // Latency of one write into an empty FIFO.
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        #1;
        chk("aa_before_edge", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("aa_out_valid", 32'(out_valid), 32'd1);
        chk("aa_out_data", 32'(out_data), 32'hAA);
        step(1'b0, '0, 1'b1);

        // Random traffic with changing bias.
        for (int i = 0; i < 1500; i++) begin
            case ((i / 250) % 3)
                0:       begin pw = 85; pr = 30; end
                1:       begin pw = 50; pr = 50; end
                default: begin pw = 20; pr = 85; end
            endcase
            step($urandom_range(0, 99) < pw, DATA_W'($urandom), $urandom_range(0, 99) < pr);
        end

        // Assert reset mid-burst with 5 entries.
        for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(i + 1), 1'b0);
        chk("mid_count_before", 32'(count), 32'd5);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, '0, 1'b0);
        chk("post_rst_count", 32'(count), 32'd0);

`ifdef PARAM_SYNC_FIFO_ERR_EN
        // Overflow flag is sticky until reset.
        for (int i = 0; i < 16; i++) step(1'b1, DATA_W'(i), 1'b0);
        chk("ovf_before", 32'(overflow_err), 32'd0);
        step(1'b1, 8'hEE, 1'b0);
        chk("ovf_set", 32'(overflow_err), 32'd1);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
        chk("ovf_sticky", 32'(overflow_err), 32'd1);
        chk("unf_set", 32'(underflow_err), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ovf_cleared", 32'(overflow_err), 32'd0);
        chk("unf_cleared", 32'(underflow_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, '0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
